// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port among NUM_REQ
// pixel-fetch requesters; returns tagged data to the originator after a fixed latency.
module sprite_rom_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic                      frame_sync,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DEPTH = ROM_LAT + 1;
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_ID   = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W:0]   scan_idx;
    logic [PTR_W-1:0] win_id;
    logic             win_vld;
    logic [DEPTH-1:0] tag_vld;
    logic [PTR_W-1:0] tag_id [DEPTH];

    // First requester at or after rr_ptr (wrapping) wins; suppressed while in reset
    always_comb begin
        gnt      = '0;
        win_vld  = 1'b0;
        win_id   = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!win_vld && req[scan_idx[PTR_W-1:0]]) begin
                win_vld = 1'b1;
                win_id  = scan_idx[PTR_W-1:0];
            end
        end
        if (win_vld && !Reset) begin
            gnt[win_id] = 1'b1;
        end
    end

    assign ptr_nxt = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
    assign busy    = |tag_vld;

    // ROM address register, tag pipeline that tracks the ROM latency, and return stage
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rr_ptr   <= '0;
            rom_addr <= '0;
            tag_vld  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_id[i] <= '0;
            end
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            if (win_vld) begin
                rom_addr <= req_addr[win_id*ADDR_W +: ADDR_W];
            end
            tag_vld[0] <= win_vld;
            tag_id[0]  <= win_id;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end

            // Vertical sync restarts the rotation even if a grant happens this edge
            if (frame_sync) begin
                rr_ptr <= '0;
            end else if (win_vld) begin
                rr_ptr <= ptr_nxt;
            end

            if (tag_vld[DEPTH-1]) begin
                rd_valid <= NUM_REQ'(1) << tag_id[DEPTH-1];
                rd_data  <= rom_data;
            end else begin
                rd_valid <= '0;
            end
        end
    end

endmodule
